// File: rtl/fp_encode_arbiter_pkg.sv
// Shared constants and types for the two-requester FP result encoder.
package fp_encode_arbiter_pkg;

    localparam int SP_EXP_BIAS = 127;
    localparam int HP_EXP_BIAS = 15;

    // Biased single-precision exponents bounding the representable half range.
    localparam int HP_OVF_EXP = 143;
    localparam int HP_UNF_EXP = 112;

    localparam logic [4:0] HP_INF_EXP = 5'h1F;

    typedef enum logic {
        MODE_HALF   = 1'b0,
        MODE_SINGLE = 1'b1
    } fp_mode_e;

    // Contents of the capture stage.
    typedef struct packed {
        logic        src;
        fp_mode_e    mode;
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } s1_data_t;

endpackage

// File: rtl/fp_encode_arbiter_encoder.sv
// IEEE-754 packer: single-precision fields straight through, or repacked as half.
// Out-of-range half exponents are corrected by the caller.
module ieee754_encoder
    import fp_encode_arbiter_pkg::*;
(
    input  fp_mode_e    mode,
    input  logic        sign,
    input  logic [7:0]  exp,
    input  logic [22:0] mant,
    output logic [31:0] result
);

    localparam logic [7:0] REBIAS = 8'(SP_EXP_BIAS - HP_EXP_BIAS);

    // Pack the fields; zero/denormal and Inf/NaN exponents keep their special codes.
    always_comb begin
        // NOTE: a default assignment first means every path drives result, so no latch is inferred.
        result = '0;
        if (mode == MODE_SINGLE) begin
            result = {sign, exp, mant};
        end else if (exp == 8'h00) begin
            result = {16'b0, sign, 5'h00, mant[22:13]};
        end else if (exp == 8'hFF) begin
            result = {16'b0, sign, HP_INF_EXP, mant[22:13]};
        end else begin
            result = {16'b0, sign, 5'(exp - REBIAS), mant[22:13]};
        end
    end

endmodule

// File: rtl/fp_encode_arbiter.sv
// Round-robin arbiter sharing one FP encode stage between two result paths,
// with a two-stage valid/ready pipeline and saturating accept counters.
module fp_encode_arbiter
    import fp_encode_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_mode_fp,
    input  logic             req0_sign,
    input  logic [7:0]       req0_exp,
    input  logic [22:0]      req0_mant,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_mode_fp,
    input  logic             req1_sign,
    input  logic [7:0]       req1_exp,
    input  logic [22:0]      req1_mant,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_src,
    output logic             out_ovf,
    output logic             out_unf,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    s1_data_t    s1_data;
    logic        s1_valid;
    logic        s2_valid;
    logic        last_grant;
    logic        s1_advance;
    logic        s1_can_accept;
    logic        grant0;
    logic        grant1;
    logic        accept0;
    logic        accept1;
    logic [31:0] enc_result;
    logic [31:0] s2_result_next;
    logic        hp_ovf;
    logic        hp_unf;
    logic [8:0]  s1_exp9;

    assign s1_advance    = s1_valid && (!s2_valid || out_ready);
    assign s1_can_accept = !s1_valid || s1_advance;

    // Round-robin grant: a lone requester wins, contention goes to the one not served last.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
    end

    assign req0_ready = grant0 && s1_can_accept;
    assign req1_ready = grant1 && s1_can_accept;
    assign accept0    = req0_valid && req0_ready;
    assign accept1    = req1_valid && req1_ready;

    // Capture stage: latch the granted requester's fields on the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: payload is reset along with the valid flag so the stage never holds X after reset.
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (accept0 || accept1) begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            s1_valid      <= 1'b1;
            s1_data.src   <= accept1;
            s1_data.mode  <= accept1 ? fp_mode_e'(req1_mode_fp) : fp_mode_e'(req0_mode_fp);
            s1_data.sign  <= accept1 ? req1_sign : req0_sign;
            s1_data.exp   <= accept1 ? req1_exp  : req0_exp;
            s1_data.mant  <= accept1 ? req1_mant : req0_mant;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    ieee754_encoder u_encoder (
        .mode   (s1_data.mode),
        .sign   (s1_data.sign),
        .exp    (s1_data.exp),
        .mant   (s1_data.mant),
        .result (enc_result)
    );

    assign s1_exp9 = {1'b0, s1_data.exp};

    // Half-range correction: clamp to signed Inf on overflow, signed zero on underflow.
    always_comb begin
        hp_ovf         = 1'b0;
        hp_unf         = 1'b0;
        s2_result_next = enc_result;
        if (s1_data.mode == MODE_HALF) begin
            if (s1_data.exp != 8'hFF && s1_exp9 >= 9'(HP_OVF_EXP)) begin
                hp_ovf         = 1'b1;
                s2_result_next = {16'b0, s1_data.sign, HP_INF_EXP, 10'b0};
            end else if (s1_data.exp != 8'h00 && s1_exp9 <= 9'(HP_UNF_EXP)) begin
                hp_unf         = 1'b1;
                s2_result_next = {16'b0, s1_data.sign, 15'b0};
            end
        end
    end

    // Output stage: load on advance, hold fields stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_src    <= 1'b0;
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
        end else if (s1_advance) begin
            s2_valid   <= 1'b1;
            out_result <= s2_result_next;
            out_src    <= s1_data.src;
            out_ovf    <= hp_ovf;
            out_unf    <= hp_unf;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign out_valid = s2_valid;

    // Grant history and saturating per-requester accept counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            cnt0       <= '0;
            cnt1       <= '0;
        end else begin
            if (accept0) begin
                last_grant <= 1'b0;
                if (cnt0 != '1) cnt0 <= cnt0 + CNT_W'(1);
            end
            if (accept1) begin
                last_grant <= 1'b1;
                if (cnt1 != '1) cnt1 <= cnt1 + CNT_W'(1);
            end
        end
    end

endmodule
